// File: rtl/dot_product_k_if.sv
// ============================================================================
// Module   : dot_product_k_if
// Brief    : Vector-in / result-out handshake bundle for dot_product_k.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dot_product_k_if #(
  parameter int W = 16,
  parameter int K = 4
);
  logic           in_v;
  logic           in_rdy;
  logic [K*W-1:0] a_flat;
  logic [W-1:0]   out;
  logic           out_sat;
  logic           out_v;
  logic           out_rdy;

  modport master (
    output in_v, a_flat, out_rdy,
    input  in_rdy, out, out_sat, out_v
  );

  modport slave (
    input  in_v, a_flat, out_rdy,
    output in_rdy, out, out_sat, out_v
  );
endinterface

`default_nettype wire

// File: rtl/dot_product_k.sv
// ============================================================================
// Module   : dot_product_k
// Brief    : K-term signed Q-format dot product with bias, round-half-up and saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dot_product_k #(
  parameter int W    = 16,
  parameter int K    = 4,
  parameter int FRAC = 12,
  // Weights 0..K-1 at [k*W +: W], bias at [K*W +: W]
  parameter logic [(K+1)*W-1:0] B_VALUES = {16'h0400, 16'h2000, 16'hF000, 16'h0800, 16'h1000}
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dot_product_k_if.slave    bus
);

  localparam int ACC_W = 2*W + $clog2(K) + 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  localparam logic signed [ACC_W-1:0] c_RND =
      (FRAC > 0) ? ({{(ACC_W-1){1'b0}}, 1'b1} << ((FRAC > 0) ? FRAC-1 : 0)) : '0;
  localparam logic signed [ACC_W-1:0] c_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_ADD   = 3'd2,
    S_SCALE = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [W-1:0]     r_a   [K];
  logic signed [W-1:0]     w_wt  [K];
  logic signed [W-1:0]     w_bias;
  logic [KW-1:0]           r_k;
  logic signed [2*W-1:0]   r_prod;
  logic signed [2*W-1:0]   w_mult;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_seed;
  logic signed [ACC_W-1:0] w_rounded;
  logic signed [ACC_W-1:0] w_scaled;
  logic signed [W-1:0]     w_sat_val;
  logic                    w_clip;
  logic                    w_last;
  logic [W-1:0]            r_out;
  logic                    r_out_sat;
  logic                    r_out_v;

  generate
    for (genvar g = 0; g < K; g++) begin : g_rom
      assign w_wt[g] = B_VALUES[g*W +: W];
    end
  endgenerate
  assign w_bias = B_VALUES[K*W +: W];

  assign w_last     = (r_k == KW'(K-1));
  assign w_mult     = r_a[r_k] * w_wt[r_k];
  assign w_prod_ext = {{(ACC_W-2*W){r_prod[2*W-1]}}, r_prod};
  assign w_seed     = {{(ACC_W-W){w_bias[W-1]}}, w_bias} <<< FRAC;
  assign w_rounded  = r_acc + c_RND;
  assign w_scaled   = w_rounded >>> FRAC;

  always_comb begin
    w_sat_val = w_scaled[W-1:0];
    w_clip    = 1'b0;
    if (w_scaled > c_MAX) begin
      w_sat_val = c_MAX[W-1:0];
      w_clip    = 1'b1;
    end else if (w_scaled < c_MIN) begin
      w_sat_val = c_MIN[W-1:0];
      w_clip    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_v) w_state_nxt = S_MULT;
      S_MULT:  if (w_last) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_SCALE;
      S_SCALE: w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.out_rdy) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Activation capture: the vector is frozen at acceptance, upstream may move on
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.in_v) begin
      for (int i = 0; i < K; i++) r_a[i] <= bus.a_flat[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k       <= '0;
      r_prod    <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_out_sat <= 1'b0;
      r_out_v   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_v) begin
          r_acc  <= w_seed;
          r_k    <= '0;
          r_prod <= '0;
        end
        S_MULT: begin
          // Product is pipelined one cycle ahead of the accumulate
          r_prod <= w_mult;
          r_acc  <= r_acc + w_prod_ext;
          r_k    <= w_last ? '0 : r_k + KW'(1);
        end
        S_ADD:   r_acc <= r_acc + w_prod_ext;
        S_SCALE: begin
          r_out     <= w_sat_val;
          r_out_sat <= w_clip;
          r_out_v   <= 1'b1;
        end
        S_HOLD:  if (bus.out_rdy) r_out_v <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_rdy  = (r_state == S_IDLE);
  assign bus.out     = r_out;
  assign bus.out_sat = r_out_sat;
  assign bus.out_v   = r_out_v;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_k.sv
// ============================================================================
// Module   : tb_dot_product_k
// Brief    : Directed and randomized bench for dot_product_k against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dot_product_k;

  localparam int W    = 16;
  localparam int K    = 4;
  localparam int FRAC = 12;
  localparam logic [(K+1)*W-1:0] BV = {16'h0400, 16'h2000, 16'hF000, 16'h0800, 16'h1000};

  // Same coefficients as BV, in real-valued Q12 integers
  int wts [K] = '{4096, 2048, -4096, 8192};
  int bias    = 1024;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  dot_product_k_if #(.W(W), .K(K)) bus ();

  dot_product_k #(.W(W), .K(K), .FRAC(FRAC), .B_VALUES(BV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [K*W-1:0] pack4(input logic [W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [K*W-1:0] rand_vec();
    logic [K*W-1:0] v;
    for (int k = 0; k < K; k++) begin
      case ($urandom_range(0, 5))
        0:       v[k*W +: W] = 16'h7FFF;
        1:       v[k*W +: W] = 16'h8000;
        default: v[k*W +: W] = W'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic model(input logic [K*W-1:0] a, output logic [W-1:0] o, output logic s);
    longint acc;
    longint r;
    acc = longint'(bias) * (longint'(1) << FRAC);
    for (int k = 0; k < K; k++)
      acc += longint'($signed(a[k*W +: W])) * longint'(wts[k]);
    r = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
    s = 1'b0;
    if (r > 32767) begin
      r = 32767;
      s = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      s = 1'b1;
    end
    o = r[W-1:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [K*W-1:0] a);
    int n = 0;
    while (!bus.in_rdy && n < 40) begin
      tick();
      n++;
    end
    chk("in_rdy_wait", 32'(bus.in_rdy), 32'd1);
    bus.in_v   = 1'b1;
    bus.a_flat = a;
    tick();
    bus.in_v   = 1'b0;
    bus.a_flat = rand_vec();
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_v && n < 40) begin
      tick();
      n++;
    end
    chk("out_v_timeout", 32'(bus.out_v), 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [K*W-1:0] a,
                         input logic [W-1:0] eo, input logic es, input int hold);
    int n;
    bus.out_rdy = (hold == 0);
    accept(a);
    wait_out(n);
    chk({tag, "_out"}, 32'(bus.out), 32'(eo));
    chk({tag, "_sat"}, 32'(bus.out_sat), 32'(es));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_v"}, 32'(bus.out_v), 32'd1);
    end
    bus.out_rdy = 1'b1;
    tick();
    chk({tag, "_v_drop"}, 32'(bus.out_v), 32'd0);
  endtask

  initial begin
    logic [K*W-1:0] nom;
    logic [K*W-1:0] rv;
    logic [W-1:0]   eo;
    logic           es;
    int             n;

    nom         = pack4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    rst         = 1'b1;
    bus.in_v    = 1'b0;
    bus.a_flat  = '0;
    bus.out_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_out_v", 32'(bus.out_v), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    rst = 1'b0;
    tick();

    // Nominal with latency and single-cycle out_v
    bus.out_rdy = 1'b1;
    accept(nom);
    chk("nom_in_rdy_busy", 32'(bus.in_rdy), 32'd0);
    wait_out(n);
    chk("nom_latency", 32'(n), 32'(K+2));
    chk("nom_out", 32'(bus.out), 32'h2C00);
    chk("nom_sat", 32'(bus.out_sat), 32'd0);
    tick();
    chk("nom_one_cycle", 32'(bus.out_v), 32'd0);
    chk("nom_in_rdy_back", 32'(bus.in_rdy), 32'd1);
    chk("nom_out_keep", 32'(bus.out), 32'h2C00);

    run_vec("sat_pos", pack4(16'h7000, 16'h0000, 16'h0000, 16'h7000), 16'h7FFF, 1'b1, 0);
    run_vec("sat_neg", pack4(16'h8000, 16'h0000, 16'h0000, 16'h8000), 16'h8000, 1'b1, 0);
    run_vec("rnd_up", pack4(16'h0000, 16'h0001, 16'h0000, 16'h0000), 16'h0401, 1'b0, 0);
    run_vec("rnd_neg", pack4(16'h0000, 16'hFFFF, 16'h0000, 16'h0000), 16'h0400, 1'b0, 0);

    // Backpressure with in_v pulses that must be ignored
    bus.out_rdy = 1'b0;
    accept(nom);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      bus.in_v   = 1'($urandom_range(0, 1));
      bus.a_flat = rand_vec();
      tick();
      chk("bp_out_v", 32'(bus.out_v), 32'd1);
      chk("bp_out", 32'(bus.out), 32'h2C00);
      chk("bp_in_rdy", 32'(bus.in_rdy), 32'd0);
    end
    bus.in_v    = 1'b0;
    bus.out_rdy = 1'b1;
    tick();
    chk("bp_release", 32'(bus.out_v), 32'd0);
    run_vec("bp_next", pack4(16'h0000, 16'h0001, 16'h0000, 16'h0000), 16'h0401, 1'b0, 0);

    // Reset during the second MULT cycle
    accept(nom);
    tick();
    rst = 1'b1;
    #2;
    chk("mid_rst_out_v", 32'(bus.out_v), 32'd0);
    chk("mid_rst_out", 32'(bus.out), 32'd0);
    chk("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_out_v", 32'(bus.out_v), 32'd0);
    run_vec("post_rst", nom, 16'h2C00, 1'b0, 0);

    // Back-to-back
    run_vec("b2b_a", nom, 16'h2C00, 1'b0, 0);
    run_vec("b2b_b", pack4(16'h0000, 16'h0001, 16'h0000, 16'h0000), 16'h0401, 1'b0, 0);

    // Randomized against the arithmetic model
    for (int t = 0; t < 24; t++) begin
      rv = rand_vec();
      model(rv, eo, es);
      run_vec("rand", rv, eo, es, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
